// File: rtl/regfile_pkg.sv
// Shared constants for the mailbox register file: default parameters and status-word layout.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_ADDR_W     = 5;
    localparam int unsigned DEF_NCH        = 3;
    localparam int unsigned DEF_EVT_W      = 4;
    localparam int unsigned DEF_MBOX_BASE  = 27;
    localparam int unsigned DEF_STATUS_REG = 26;
    localparam int unsigned DEF_DBG_N      = 3;

    // Status word field layout
    localparam int unsigned PEND_LSB  = 0;
    localparam int unsigned STALL_LSB = 16;
    localparam int unsigned STALL_W   = 8;
    localparam int unsigned STALL_MAX = 255;

endpackage

// File: rtl/regfile_mbox_chan.sv
// One game-event mailbox channel: pending flag, ready logic and capture strobe.
module regfile_mbox_chan (
    input  logic clock,
    input  logic ctrl_reset,
    input  logic evtValid,
    input  logic cpuWrite,
    output logic evtReady_c,
    output logic capture_c,
    output logic pend
);

    // Accept only when the previous event has been consumed and not in reset
    always_comb begin
        evtReady_c = !pend && !ctrl_reset;
        capture_c  = evtValid && evtReady_c;
    end

    // Pending flag: set on capture (wins over a same-cycle CPU write), cleared by CPU write
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            pend <= 1'b0;
        end else if (capture_c) begin
            pend <= 1'b1;
        end else if (cpuWrite) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mbox.sv
// CPU register file with game-event mailboxes, a read-only status register and debug taps.
// Optional macro REGFILE_FWD_EN: same-cycle write-to-read forwarding.
module regfile_mbox
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned NCH        = DEF_NCH,
    parameter int unsigned EVT_W      = DEF_EVT_W,
    parameter int unsigned MBOX_BASE  = DEF_MBOX_BASE,
    parameter int unsigned STATUS_REG = DEF_STATUS_REG,
    parameter int unsigned DBG_N      = DEF_DBG_N
) (
    input  logic                    clock,
    input  logic                    ctrl_reset,
    input  logic                    ctrl_writeEnable,
    input  logic [ADDR_W-1:0]       ctrl_writeReg,
    input  logic [DATA_W-1:0]       data_writeReg,
    input  logic [ADDR_W-1:0]       ctrl_readRegA,
    input  logic [ADDR_W-1:0]       ctrl_readRegB,
    output logic [DATA_W-1:0]       data_readRegA,
    output logic [DATA_W-1:0]       data_readRegB,
    input  logic [NCH-1:0]          evt_valid,
    input  logic [NCH*EVT_W-1:0]    evt_data,
    output logic [NCH-1:0]          evt_ready,
    output logic [DBG_N*DATA_W-1:0] dbg_regs
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] STATUS_IDX = ADDR_W'(STATUS_REG);

    // Parameter sanity checks
    if (MBOX_BASE + NCH - 1 >= DEPTH) begin : gErrMboxRange
        $error("regfile_mbox: mailbox range exceeds register depth");
    end
    if (STATUS_REG >= MBOX_BASE && STATUS_REG < MBOX_BASE + NCH) begin : gErrStatusOverlap
        $error("regfile_mbox: STATUS_REG overlaps mailbox range");
    end
    if (STATUS_REG == 0 || MBOX_BASE == 0) begin : gErrZeroIdx
        $error("regfile_mbox: STATUS_REG and MBOX_BASE must be nonzero");
    end
    if (DBG_N >= DEPTH) begin : gErrDbg
        $error("regfile_mbox: DBG_N too large");
    end
    if (EVT_W > DATA_W) begin : gErrEvtW
        $error("regfile_mbox: EVT_W exceeds DATA_W");
    end

    logic [DATA_W-1:0]  regs [DEPTH];
    logic [NCH-1:0]     pend;
    logic [NCH-1:0]     capture;
    logic [STALL_W-1:0] stallCnt;
    logic               wrCommit;
    logic               statusWr;
    logic               stallAny;
    logic [DATA_W-1:0]  statusWord;

    // Per-channel mailbox control
    for (genvar k = 0; k < NCH; k++) begin : gChan
        logic cpuWr;
        assign cpuWr = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(MBOX_BASE + k));
        regfile_mbox_chan uChan (
            .clock      (clock),
            .ctrl_reset (ctrl_reset),
            .evtValid   (evt_valid[k]),
            .cpuWrite   (cpuWr),
            .evtReady_c (evt_ready[k]),
            .capture_c  (capture[k]),
            .pend       (pend[k])
        );
    end

    // Write qualification and stall detection
    always_comb begin
        wrCommit = ctrl_writeEnable && (ctrl_writeReg != '0) && (ctrl_writeReg != STATUS_IDX);
        statusWr = ctrl_writeEnable && (ctrl_writeReg == STATUS_IDX);
        stallAny = !ctrl_reset && (|(evt_valid & ~evt_ready));
    end

`ifdef REGFILE_FWD_EN
    logic wrKeep;

    // A write survives unless a same-cycle event capture claims its mailbox
    always_comb begin
        wrKeep = wrCommit;
        for (int k = 0; k < NCH; k++) begin
            if (capture[k] && (ctrl_writeReg == ADDR_W'(MBOX_BASE + k))) begin
                wrKeep = 1'b0;
            end
        end
    end
`endif

    // Storage update: captured events are applied last so they override CPU writes
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else begin
            if (wrCommit) begin
                regs[ctrl_writeReg] <= data_writeReg;
            end
            for (int k = 0; k < NCH; k++) begin
                if (capture[k]) begin
                    regs[ADDR_W'(MBOX_BASE + k)] <= DATA_W'(evt_data[k*EVT_W +: EVT_W]);
                end
            end
        end
    end

    // Saturating stall counter; a status write clears it ahead of any increment
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            stallCnt <= '0;
        end else if (statusWr) begin
            stallCnt <= '0;
        end else if (stallAny && (stallCnt != STALL_W'(STALL_MAX))) begin
            stallCnt <= stallCnt + STALL_W'(1);
        end
    end

    // Status word assembly
    always_comb begin
        statusWord = '0;
        statusWord[PEND_LSB +: NCH]      = pend;
        statusWord[STALL_LSB +: STALL_W] = stallCnt;
    end

    // Read port A
    always_comb begin
        data_readRegA = regs[ctrl_readRegA];
`ifdef REGFILE_FWD_EN
        if (wrKeep && (ctrl_readRegA == ctrl_writeReg)) begin
            data_readRegA = data_writeReg;
        end
`endif
        if (ctrl_readRegA == STATUS_IDX) begin
            data_readRegA = statusWord;
        end
        if (ctrl_readRegA == '0) begin
            data_readRegA = '0;
        end
    end

    // Read port B
    always_comb begin
        data_readRegB = regs[ctrl_readRegB];
`ifdef REGFILE_FWD_EN
        if (wrKeep && (ctrl_readRegB == ctrl_writeReg)) begin
            data_readRegB = data_writeReg;
        end
`endif
        if (ctrl_readRegB == STATUS_IDX) begin
            data_readRegB = statusWord;
        end
        if (ctrl_readRegB == '0) begin
            data_readRegB = '0;
        end
    end

    // Debug taps on registers 1..DBG_N
    for (genvar g = 0; g < DBG_N; g++) begin : gDbg
        assign dbg_regs[g*DATA_W +: DATA_W] = regs[ADDR_W'(g + 1)];
    end

endmodule

// File: tb/tb_regfile_mbox.sv
// Scoreboard bench for regfile_mbox: stimulus queues expectations, a negedge monitor checks them.
module tb_regfile_mbox;

    localparam int F_RDA = 0;
    localparam int F_RDB = 1;
    localparam int F_RDY = 2;
    localparam int F_DBG2 = 3;

    typedef struct {
        int          cyc;
        int          field;
        logic [31:0] exp;
    } sbItem_t;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic [2:0]  evt_valid;
    logic [11:0] evt_data;
    logic [2:0]  evt_ready;
    logic [95:0] dbg_regs;

    int      cycCnt = 0;
    int      checks = 0;
    int      errors = 0;
    sbItem_t sbQ[$];
    sbItem_t item;
    logic [31:0] got;

    regfile_mbox dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .evt_valid        (evt_valid),
        .evt_data         (evt_data),
        .evt_ready        (evt_ready),
        .dbg_regs         (dbg_regs)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycCnt <= cycCnt + 1;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clock) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cycCnt) begin
            item = sbQ.pop_front();
            case (item.field)
                F_RDA:   got = data_readRegA;
                F_RDB:   got = data_readRegB;
                F_RDY:   got = {29'd0, evt_ready};
                default: got = dbg_regs[63:32];
            endcase
            checks++;
            if (got !== item.exp || item.cyc != cycCnt) begin
                errors++;
                $display("FAIL field%0d cyc %0d got %h exp %h (due cyc %0d)",
                         item.field, cycCnt, got, item.exp, item.cyc);
            end
        end
    end

    task automatic nextCyc();
        @(posedge clock);
        #1;
    endtask

    task automatic pushExp(input int f, input logic [31:0] v);
        sbItem_t e;
        e.cyc   = cycCnt;
        e.field = f;
        e.exp   = v;
        sbQ.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb,
                         input logic [2:0] ev, input logic [11:0] ed);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        evt_valid        = ev;
        evt_data         = ed;
    endtask

    initial begin
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 3'b000, 12'h000);
        nextCyc();
        pushExp(F_RDY, 32'h0);
        nextCyc();
        ctrl_reset = 1'b0;

        // First cycle out of reset
        drive(1'b0, 5'd0, 32'd0, 5'd5, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDY, 32'h7);
        pushExp(F_RDB, 32'h0);
        nextCyc();

        // All registers read zero
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'(2*i), 5'(2*i+1), 3'b000, 12'h000);
            pushExp(F_RDA, 32'h0);
            pushExp(F_RDB, 32'h0);
            nextCyc();
        end

        // Plain write, same-cycle read then next-cycle read
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 3'b000, 12'h000);
`ifdef REGFILE_FWD_EN
        pushExp(F_RDA, 32'hDEADBEEF);
`else
        pushExp(F_RDA, 32'h0);
`endif
        nextCyc();
        drive(1'b1, 5'd2, 32'h00000022, 5'd5, 5'd0, 3'b000, 12'h000);
        pushExp(F_RDA, 32'hDEADBEEF);
        nextCyc();
        drive(1'b1, 5'd0, 32'h00000055, 5'd0, 5'd2, 3'b000, 12'h000);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h22);
        pushExp(F_DBG2, 32'h22);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd5, 3'b000, 12'h000);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'hDEADBEEF);
        nextCyc();

        // Channel 0 event, then stall for three cycles
        drive(1'b0, 5'd0, 32'd0, 5'd27, 5'd26, 3'b001, 12'h005);
        pushExp(F_RDY, 32'h7);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h0);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd27, 5'd26, 3'b001, 12'h007);
        pushExp(F_RDY, 32'h6);
        pushExp(F_RDA, 32'h5);
        pushExp(F_RDB, 32'h00000001);
        nextCyc();
        pushExp(F_RDB, 32'h00010001);
        nextCyc();
        pushExp(F_RDB, 32'h00020001);
        nextCyc();
        // CPU consumes channel 0 while the source keeps offering
        drive(1'b1, 5'd27, 32'h0, 5'd27, 5'd26, 3'b001, 12'h007);
        pushExp(F_RDB, 32'h00030001);
`ifdef REGFILE_FWD_EN
        pushExp(F_RDA, 32'h0);
`else
        pushExp(F_RDA, 32'h5);
`endif
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd27, 5'd26, 3'b001, 12'h007);
        pushExp(F_RDY, 32'h7);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h00040000);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd27, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDY, 32'h6);
        pushExp(F_RDA, 32'h7);
        pushExp(F_RDB, 32'h00040001);
        nextCyc();

        // Status write clears stall counter, pend untouched, no forwarding
        drive(1'b1, 5'd26, 32'hFFFFFFFF, 5'd26, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDA, 32'h00040001);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd26, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDA, 32'h00000001);
        nextCyc();

        // Event and CPU write to the same mailbox in one cycle: event wins
        drive(1'b1, 5'd28, 32'h00001234, 5'd28, 5'd26, 3'b010, 12'h0A0);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDY, 32'h6);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd28, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDA, 32'hA);
        pushExp(F_RDB, 32'h00000003);
        pushExp(F_RDY, 32'h4);
        nextCyc();

        // Long stall on channel 1 saturates the counter
        for (int i = 0; i <= 300; i++) begin
            drive(1'b0, 5'd0, 32'd0, 5'd28, 5'd26, 3'b010, 12'h0B0);
            if (i == 254) pushExp(F_RDB, 32'h00FE0003);
            if (i == 255) pushExp(F_RDB, 32'h00FF0003);
            if (i == 300) pushExp(F_RDB, 32'h00FF0003);
            nextCyc();
        end
        // Clear while still stalling: clear wins
        drive(1'b1, 5'd26, 32'h0, 5'd28, 5'd26, 3'b010, 12'h0B0);
        pushExp(F_RDB, 32'h00FF0003);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd28, 5'd26, 3'b010, 12'h0B0);
        pushExp(F_RDB, 32'h00000003);
        pushExp(F_RDA, 32'hA);
        nextCyc();

        // Build pend = 101 then reset mid-stall
        drive(1'b1, 5'd28, 32'h99, 5'd28, 5'd26, 3'b000, 12'h000);
        pushExp(F_RDB, 32'h00010003);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd28, 5'd26, 3'b100, 12'hC00);
        pushExp(F_RDA, 32'h99);
        pushExp(F_RDB, 32'h00010001);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd26, 3'b101, 12'h00F);
        pushExp(F_RDA, 32'hC);
        pushExp(F_RDB, 32'h00010005);
        pushExp(F_RDY, 32'h2);
        nextCyc();
        ctrl_reset = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 5'd27, 5'd26, 3'b111, 12'hFFF);
        pushExp(F_RDY, 32'h0);
        pushExp(F_RDB, 32'h00020005);
        nextCyc();
        pushExp(F_RDY, 32'h0);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h0);
        nextCyc();
        ctrl_reset = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd5, 3'b000, 12'h000);
        pushExp(F_RDY, 32'h7);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h0);
        pushExp(F_DBG2, 32'h0);
        nextCyc();
        drive(1'b0, 5'd0, 32'd0, 5'd26, 5'd28, 3'b000, 12'h000);
        pushExp(F_RDA, 32'h0);
        pushExp(F_RDB, 32'h0);
        nextCyc();

        // Drain scoreboard with a bound
        for (int i = 0; i < 10 && sbQ.size() > 0; i++) begin
            @(negedge clock);
        end
        if (sbQ.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expectations left, required 0", sbQ.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
